// File: rtl/apb_pkg.sv
// Shared types for the APB slave register block: transfer FSM states and
// the width of the wait-state counter.
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Wide enough for the largest supported wait count (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB slave: byte-strobed writes, one-cycle update
// pulses and the read mux. Register 0 is a constant identification value.
module apb_regbank #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned IW     = 4,
  parameter logic [31:0] ID_VAL = 32'hA5B0_0001
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [IW-1:0]      idx_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic [DW/8-1:0]    strb_i,
  output logic [NREG*DW-1:0] regs_o,
  output logic [NREG-1:0]    wr_pulse_o,
  output logic [DW-1:0]      rdata_o
);

  logic [DW-1:0]   mem_q [NREG-1:1];
  logic [DW-1:0]   mem_d [NREG-1:1];
  logic [NREG-1:0] pulse_q, pulse_d;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]   old_v,
                                                input logic [DW-1:0]   new_v,
                                                input logic [DW/8-1:0] strb_v);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < DW / 8; b++) begin
      res[b*8 +: 8] = strb_v[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Next-state of the storage: only the addressed register takes the merge.
  always_comb begin
    pulse_d = {NREG{1'b0}};
    for (int k = 1; k < NREG; k++) begin
      mem_d[k] = mem_q[k];
      if (we_i && (idx_i == IW'(k))) begin
        mem_d[k]   = merge_bytes(mem_q[k], wdata_i, strb_i);
        pulse_d[k] = 1'b1;
      end else begin
        pulse_d[k] = 1'b0;
      end
    end
  end

  // Storage and pulse registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k < NREG; k++) begin
        mem_q[k] <= {DW{1'b0}};
      end
      pulse_q <= {NREG{1'b0}};
    end else begin
      mem_q   <= mem_d;
      pulse_q <= pulse_d;
    end
  end

  // Read mux; index 0 and anything unmatched fall back to the ID constant.
  always_comb begin
    rdata_o = DW'(ID_VAL);
    for (int k = 1; k < NREG; k++) begin
      rdata_o = (idx_i == IW'(k)) ? mem_q[k] : rdata_o;
    end
  end

  assign regs_o[DW-1:0] = DW'(ID_VAL);
  for (genvar k = 1; k < NREG; k++) begin : g_regs
    assign regs_o[k*DW +: DW] = mem_q[k];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave register file: setup/access FSM with programmable wait states,
// address and permission decode, backed by apb_regbank.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 8,
  parameter int unsigned NREG     = 16,
  parameter int unsigned WAIT_CYC = 0,
  parameter logic [31:0] ID_VAL   = 32'hA5B0_0001
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [AW-1:0]      i_paddr,
  input  logic               i_pwrite,
  input  logic               i_psel,
  input  logic               i_penable,
  input  logic [DW-1:0]      i_pwdata,
  input  logic [DW/8-1:0]    i_pstrb,
  output logic [DW-1:0]      o_prdata,
  output logic               o_pslverr,
  output logic               o_pready,
  output logic [NREG*DW-1:0] o_regs,
  output logic [NREG-1:0]    o_wr_pulse
);

  localparam int unsigned      SW      = DW / 8;
  localparam int unsigned      IW      = $clog2(NREG);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);
  localparam logic [31:0]      NREG_W  = 32'(NREG);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    strb_q, strb_d;
  logic             err_q, err_d;

  logic [31:0]      word_s;
  logic [IW-1:0]    idx_s;
  logic             err_s;
  logic             ready_s;
  logic             done_s;
  logic             we_s;
  logic [DW-1:0]    rdata_s;

  // The full word address is range-checked so aliases above NREG still error.
  assign word_s = 32'(i_paddr[AW-1:2]);
  assign idx_s  = i_paddr[IW+1:2];
  assign err_s  = (i_paddr[1:0] != 2'b00) || (word_s >= NREG_W) ||
                  (i_pwrite && (word_s == 32'd0));

  assign ready_s = !preset && (state_q == ACCESS) && (cnt_q == {CNT_W{1'b0}});
  assign done_s  = ready_s && i_psel && i_penable;
  assign we_s    = done_s && wr_q && !err_q && (strb_q != {SW{1'b0}});

  // Transfer FSM, wait counter and setup-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LD;
          wr_d    = i_pwrite;
          idx_d   = idx_s;
          wdata_d = i_pwdata;
          strb_d  = i_pstrb;
          err_d   = err_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (done_s) begin
          state_d = IDLE;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wr_q    <= 1'b0;
      idx_q   <= {IW{1'b0}};
      wdata_q <= {DW{1'b0}};
      strb_q  <= {SW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
    end
  end

  apb_regbank #(
    .DW     (DW),
    .NREG   (NREG),
    .IW     (IW),
    .ID_VAL (ID_VAL)
  ) u_regbank (
    .clk_i      (pclk),
    .rst_i      (preset),
    .we_i       (we_s),
    .idx_i      (idx_q),
    .wdata_i    (wdata_q),
    .strb_i     (strb_q),
    .regs_o     (o_regs),
    .wr_pulse_o (o_wr_pulse),
    .rdata_o    (rdata_s)
  );

  assign o_pready  = ready_s;
  assign o_pslverr = done_s && err_q;
  assign o_prdata  = (done_s && !wr_q && !err_q) ? rdata_s : {DW{1'b0}};

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-002 SHALL have parameter AW, default 8, byte-address width (max 32).
REQ-003 SHALL have parameter NREG, default 16, number of 32-bit-aligned registers (2..2^(AW-2)).
REQ-004 SHALL have parameter WAIT_CYC, default 0, wait states inserted per access (0..15).
REQ-005 SHALL have parameter ID_VAL, default 32'hA5B0_0001, constant value of register 0.
REQ-006 SHALL derive SW = DW/8 and IW = $clog2(NREG) as localparams.
REQ-007 pclk  in  1  clock; all logic rising-edge.
REQ-008 preset  in  1  reset; one clock; reset is synchronous and active-high.
REQ-009 i_paddr  in  AW  APB byte address.
REQ-010 i_pwrite  in  1  1 = write, 0 = read.
REQ-011 i_psel  in  1  slave select.
REQ-012 i_penable  in  1  access phase.
REQ-013 i_pwdata  in  DW  write data.
REQ-014 i_pstrb  in  SW  write byte strobes.
REQ-015 o_prdata  out  DW  read data.
REQ-016 o_pslverr  out  1  transfer error.
REQ-017 o_pready  out  1  transfer complete.
REQ-018 o_regs  out  NREG*DW  flat register contents, register k at [k*DW+:DW].
REQ-019 o_wr_pulse  out  NREG  one-cycle pulse per register updated.

Function
REQ-020 FSM SHALL have states IDLE and ACCESS.
REQ-021 IDLE -> ACCESS when i_psel=1 and i_penable=0 (setup); SHALL latch write flag, address, wdata, strobes, and decoded error; SHALL load wait counter with WAIT_CYC.
REQ-022 In ACCESS, o_pready SHALL equal (counter==0); counter SHALL decrement while nonzero.
REQ-023 ACCESS -> IDLE on the cycle i_psel=1, i_penable=1, o_pready=1 (completion cycle).
REQ-024 ACCESS -> IDLE without write or response if i_psel=0 (master abort).
REQ-025 WAIT_CYC=0 SHALL give zero-wait transfers: o_pready=1 on first access cycle.
REQ-026 Register index = i_paddr[IW+1:2]; error when i_paddr[1:0]!=0, index>=NREG, or write to index 0.
REQ-027 On completion without error, write SHALL update only bytes with strobe set; register visible on o_regs next cycle, with corresponding o_wr_pulse high that same cycle only.
REQ-028 Write with all strobes zero SHALL complete without error, no update, no pulse.
REQ-029 o_prdata SHALL be register value on error-free read completion cycle, else 0.
REQ-030 o_pslverr SHALL be 1 only on completion cycle of an erroring transfer; erroring write SHALL not modify any register.
REQ-031 o_pready, o_pslverr SHALL be 0 in IDLE.
REQ-032 Back-to-back transfers (completion followed directly by setup) SHALL be handled with no dead cycle.
REQ-033 Register 0 SHALL always read ID_VAL.

Reset
REQ-034 preset SHALL force IDLE, counter 0, registers 1..NREG-1 to 0, o_wr_pulse 0, o_pready/o_pslverr/o_prdata 0.
REQ-035 Reset mid-transfer SHALL abandon transfer with no register update.

Structure
REQ-036 state_t enum (IDLE, ACCESS) SHALL live in shared package apb_pkg.
REQ-037 Register storage and strobe merge SHALL be sub-module apb_regbank; FSM, counter, decode in top.

Verification (DW=32, AW=8, NREG=16, WAIT_CYC=2)
REQ-038 Write 0x04 data 0xDEADBEEF strb 0xF -> pready after 2 wait cycles, pslverr=0, o_wr_pulse[1] one cycle, reg1=0xDEADBEEF.
REQ-039 Write 0x04 data 0x11223344 strb 0x5 after REQ-038 -> reg1=0xDE22BE44; read 0x04 -> prdata 0xDE22BE44.
REQ-040 Read 0x00 -> prdata 0xA5B00001; write 0x00 -> pslverr=1, no pulse, reg0 unchanged.
REQ-041 Read 0x40 (index 16) and write 0x05 (misaligned) -> pslverr=1, prdata=0, no register change.
REQ-042 Assert preset during wait state of write to 0x08 -> pready stays 0, reg2=0, FSM IDLE next cycle.
REQ-043 WAIT_CYC=0 build, back-to-back write 0x08 then read 0x08 -> each completes first access cycle, read returns written data.
